// File: rtl/read_arbiter.sv
// rtl/read_arbiter.sv - shared SRAM read-port arbiter (SP / WRR) with tagged return path
// One SRAM read issued per cycle; a port tag follows each read so the data returns to its owner.
module read_arbiter #(
  parameter int NUM_PORTS    = 16,
  parameter int DATA_WIDTH   = 256,
  parameter int ADDR_WIDTH   = 14,
  parameter int WEIGHT_WIDTH = 4,
  parameter int RD_LATENCY   = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             sp0_wrr1,
  input  logic [NUM_PORTS-1:0]             req_p,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr_in_p,
  input  logic [NUM_PORTS*WEIGHT_WIDTH-1:0] weight_p,
  output logic [NUM_PORTS-1:0]             gnt,
  output logic                             sram_rd_en,
  output logic [ADDR_WIDTH-1:0]            sram_rd_addr,
  input  logic [DATA_WIDTH-1:0]            sram_rd_data,
  output logic [DATA_WIDTH-1:0]            data_out,
  output logic [NUM_PORTS-1:0]             data_valid
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W = WEIGHT_WIDTH + 1;

  logic [IDX_W-1:0]        cur;
  logic [CNT_W-1:0]        cnt;
  logic                    sp_hit;
  logic [IDX_W-1:0]        sp_idx;
  logic [WEIGHT_WIDTH-1:0] cur_w;
  logic [CNT_W-1:0]        eff_w;
  logic                    stay;
  logic                    wrap_hit;
  logic [IDX_W-1:0]        wrap_idx;
  logic                    win_hit;
  logic [IDX_W-1:0]        win_idx;
  logic                    win_stay;
  logic [IDX_W-1:0]        issue_port;
  logic [RD_LATENCY:0]     tag_v;
  logic [IDX_W-1:0]        tag_p [RD_LATENCY+1];
  logic [NUM_PORTS-1:0]    ret_onehot;

  always_comb begin
    sp_hit = 1'b0;
    sp_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req_p[i]) begin
        sp_hit = 1'b1;
        sp_idx = IDX_W'(i);
      end
    end

    cur_w = weight_p[cur*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    eff_w = (cur_w == '0) ? CNT_W'(1) : CNT_W'(cur_w);
    stay  = req_p[cur] && (cnt < eff_w);

    // Descending scan so the nearest port after cur wins; k = NUM_PORTS revisits cur last.
    wrap_hit = 1'b0;
    wrap_idx = cur;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      if (req_p[(int'(cur) + k) % NUM_PORTS]) begin
        wrap_hit = 1'b1;
        wrap_idx = IDX_W'((int'(cur) + k) % NUM_PORTS);
      end
    end

    if (sp0_wrr1) begin
      win_hit = stay | wrap_hit;
      win_idx = stay ? cur : wrap_idx;
    end else begin
      win_hit = sp_hit;
      win_idx = sp_idx;
    end
    win_stay = sp0_wrr1 & stay;
  end

  always_comb begin
    gnt        = '0;
    ret_onehot = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      gnt[i]        = rst & win_hit & (win_idx == IDX_W'(i));
      ret_onehot[i] = (tag_p[RD_LATENCY] == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur          <= '0;
      cnt          <= '0;
      sram_rd_en   <= 1'b0;
      sram_rd_addr <= '0;
      issue_port   <= '0;
      tag_v        <= '0;
      for (int s = 0; s <= RD_LATENCY; s++) tag_p[s] <= '0;
      data_out     <= '0;
      data_valid   <= '0;
    end else begin
      if (win_hit && sp0_wrr1) begin
        if (win_stay) begin
          cnt <= cnt + CNT_W'(1);
        end else begin
          cur <= win_idx;
          cnt <= CNT_W'(1);
        end
      end

      sram_rd_en <= win_hit;
      if (win_hit) begin
        sram_rd_addr <= addr_in_p[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
        issue_port   <= win_idx;
      end

      // Tag stage 0 lines up with the SRAM sampling the strobe; the last stage meets the data.
      tag_v    <= {tag_v[RD_LATENCY-1:0], sram_rd_en};
      tag_p[0] <= issue_port;
      for (int s = 1; s <= RD_LATENCY; s++) tag_p[s] <= tag_p[s-1];

      if (tag_v[RD_LATENCY]) begin
        data_out   <= sram_rd_data;
        data_valid <= ret_onehot;
      end else begin
        data_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_read_arbiter.sv
// tb/tb_read_arbiter.sv - directed self-checking bench for read_arbiter
// SRAM model returns data = address, visible RD_LATENCY cycles after it samples the strobe.
module tb_read_arbiter;

  localparam int NP = 16;
  localparam int DW = 256;
  localparam int AW = 14;
  localparam int WW = 4;
  localparam int L  = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           mode = 1'b0;
  logic [NP-1:0]  req = '0;
  logic [AW-1:0]  a [NP];
  logic [WW-1:0]  w [NP];
  logic [NP*AW-1:0] addr_p;
  logic [NP*WW-1:0] wt_p;
  logic [NP-1:0]  gnt;
  logic           rd_en;
  logic [AW-1:0]  rd_addr;
  logic [DW-1:0]  rd_data;
  logic [DW-1:0]  dout;
  logic [NP-1:0]  dv;
  logic [AW-1:0]  d [L+1];

  int n_cmp  = 0;
  int n_fail = 0;

  read_arbiter #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WEIGHT_WIDTH(WW), .RD_LATENCY(L)
  ) dut (
    .clk(clk), .rst(rst), .sp0_wrr1(mode), .req_p(req), .addr_in_p(addr_p),
    .weight_p(wt_p), .gnt(gnt), .sram_rd_en(rd_en), .sram_rd_addr(rd_addr),
    .sram_rd_data(rd_data), .data_out(dout), .data_valid(dv)
  );

  always #5 clk = ~clk;

  always_comb begin
    addr_p = '0;
    wt_p   = '0;
    for (int i = 0; i < NP; i++) begin
      addr_p[i*AW +: AW] = a[i];
      wt_p[i*WW +: WW]   = w[i];
    end
  end

  always @(posedge clk) begin
    d[0] <= rd_addr;
    for (int k = 1; k <= L; k++) d[k] <= d[k-1];
  end
  assign rd_data = DW'(d[L]);

  task automatic test_reset();
    for (int i = 0; i < NP; i++) begin a[i] = AW'(i); w[i] = '0; end
    req = 16'h00FF;
    @(negedge clk); @(negedge clk);
    n_cmp++; if (gnt !== '0)     begin n_fail++; $display("FAIL reset_gnt: got %h want 0", gnt); end
    n_cmp++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
    n_cmp++; if (rd_addr !== '0) begin n_fail++; $display("FAIL reset_rd_addr: got %h want 0", rd_addr); end
    n_cmp++; if (dout !== '0)    begin n_fail++; $display("FAIL reset_data_out: got %h want 0", dout); end
    n_cmp++; if (dv !== '0)      begin n_fail++; $display("FAIL reset_data_valid: got %h want 0", dv); end
    req = '0;
    rst = 1'b1;
  endtask

  task automatic test_idle();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_cmp++; if (gnt !== '0)     begin n_fail++; $display("FAIL idle_gnt c%0d: got %h want 0", c, gnt); end
      n_cmp++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL idle_rd_en c%0d: got %b want 0", c, rd_en); end
      n_cmp++; if (dv !== '0)      begin n_fail++; $display("FAIL idle_dv c%0d: got %h want 0", c, dv); end
    end
  endtask

  task automatic test_sp_contention();
    @(negedge clk);
    mode = 1'b0;
    req  = 16'h8006;
    for (int c = 0; c < 8; c++) begin
      #1;
      n_cmp++; if (gnt !== 16'h0002) begin n_fail++; $display("FAIL sp_gnt c%0d: got %h want 0002", c, gnt); end
      if (c > 0) begin
        n_cmp++; if (rd_en !== 1'b1)  begin n_fail++; $display("FAIL sp_rd_en c%0d: got %b want 1", c, rd_en); end
        n_cmp++; if (rd_addr !== 14'd1) begin n_fail++; $display("FAIL sp_rd_addr c%0d: got %h want 1", c, rd_addr); end
      end
      @(negedge clk);
    end
    req = '0;
  endtask

  task automatic test_wrr_weights();
    int seq [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    logic [NP-1:0] exp_g;
    @(negedge clk);
    mode = 1'b1;
    w[0] = 4'd3;
    w[1] = 4'd1;
    req  = 16'h0003;
    for (int r = 0; r < 2; r++) begin
      if (r == 1) w[1] = 4'd0;
      for (int c = 0; c < 8; c++) begin
        #1;
        exp_g = NP'(1) << seq[c];
        n_cmp++; if (gnt !== exp_g) begin n_fail++; $display("FAIL wrr_gnt r%0d c%0d: got %h want %h", r, c, gnt, exp_g); end
        @(negedge clk);
      end
    end
    req = '0;
  endtask

  task automatic test_latency_order();
    logic [NP-1:0] exp_dv;
    logic [DW-1:0] exp_d;
    mode = 1'b0;
    req  = '0;
    for (int i = 0; i < NP; i++) a[i] = AW'(14'h100 + i);
    repeat (6) @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      case (c)
        0, 2:    req = 16'h0008;
        1:       req = 16'h0020;
        default: req = '0;
      endcase
      #1;
      n_cmp++; if (gnt !== req) begin n_fail++; $display("FAIL lat_gnt c%0d: got %h want %h", c, gnt, req); end
      case (c)
        5, 7:    begin exp_dv = 16'h0008; exp_d = DW'(14'h103); end
        6:       begin exp_dv = 16'h0020; exp_d = DW'(14'h105); end
        default: begin exp_dv = '0;       exp_d = '0;            end
      endcase
      n_cmp++; if (dv !== exp_dv) begin n_fail++; $display("FAIL lat_dv c%0d: got %h want %h", c, dv, exp_dv); end
      if (exp_dv != '0) begin
        n_cmp++; if (dout !== exp_d) begin n_fail++; $display("FAIL lat_data c%0d: got %h want %h", c, dout, exp_d); end
      end
      @(negedge clk);
    end
    n_cmp++; if (dout !== DW'(14'h103)) begin n_fail++; $display("FAIL lat_data_hold: got %h want 103", dout); end
  endtask

  task automatic test_reset_mid_flight();
    mode = 1'b1;
    a[4] = 14'h0AB;
    req  = 16'h0010;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (gnt !== '0)     begin n_fail++; $display("FAIL rstmid_gnt: got %h want 0", gnt); end
    n_cmp++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_rd_en: got %b want 0", rd_en); end
    n_cmp++; if (rd_addr !== '0) begin n_fail++; $display("FAIL rstmid_rd_addr: got %h want 0", rd_addr); end
    n_cmp++; if (dout !== '0)    begin n_fail++; $display("FAIL rstmid_data_out: got %h want 0", dout); end
    n_cmp++; if (dv !== '0)      begin n_fail++; $display("FAIL rstmid_dv: got %h want 0", dv); end
    @(negedge clk);
    @(negedge clk);
    req = '0;
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_cmp++; if (dv !== '0) begin n_fail++; $display("FAIL rstmid_no_dv c%0d: got %h want 0", c, dv); end
    end
    req = 16'h0030;
    #1;
    n_cmp++; if (gnt !== 16'h0010) begin n_fail++; $display("FAIL rstmid_wrr_restart: got %h want 0010", gnt); end
    @(negedge clk);
    req = '0;
  endtask

  task automatic test_mode_switch();
    logic [NP-1:0] exp_g [3] = '{16'h0004, 16'h0001, 16'h0002};
    w[0] = 4'd1;
    w[2] = 4'd2;
    mode = 1'b1;
    req  = 16'h0004;
    #1;
    n_cmp++; if (gnt !== 16'h0004) begin n_fail++; $display("FAIL ms_setup_gnt: got %h want 0004", gnt); end
    @(negedge clk);
    mode = 1'b0;
    req  = 16'h0007;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (gnt !== 16'h0001) begin n_fail++; $display("FAIL ms_sp_gnt c%0d: got %h want 0001", c, gnt); end
      @(negedge clk);
    end
    mode = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (gnt !== exp_g[c]) begin n_fail++; $display("FAIL ms_wrr_gnt c%0d: got %h want %h", c, gnt, exp_g[c]); end
      @(negedge clk);
    end
    req = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle();
    test_sp_contention();
    test_wrr_weights();
    test_latency_order();
    test_reset_mid_flight();
    test_mode_switch();
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
